satatrn_txmux: RTL
==================

Name: satatrn_txmux

Overview:
- Next-generation SATA transport transmit arbiter, fully in the PHY clock domain.
- Merges NCHAN packetised register-FIS sources and one DATA payload source onto a single 32-bit FIS stream towards the link layer.
- Register sources are served round-robin. The DATA source has priority whenever the (synchronised) transmit gate is open; the block prefixes each DATA FIS with its header word and splits long payloads into multiple DATA FIS of at most MAXDATA payload words.

Parameters:
- NCHAN, 2, number of register-FIS input channels (1..8).
- MAXDATA, 2048, maximum payload words per DATA FIS (power of two, >=2).
- OPT_LOWPOWER, 1'b0, force o_data/o_last to zero whenever o_valid is low.

Ports:
- i_phy_clk  input  1  PHY transmit clock.
- i_phy_reset_n  input  1  reset.
- i_reg_valid  input  NCHAN  per-channel register FIS word valid.
- o_reg_ready  output  NCHAN  per-channel ready.
- i_reg_data  input  32*NCHAN  channel k occupies bits [32k+31:32k].
- i_reg_last  input  NCHAN  per-channel last word of FIS.
- i_txgate  input  1  DATA transmit permission, asynchronous to i_phy_clk.
- i_data_valid  input  1  payload word valid.
- o_data_ready  output  1  payload word accepted.
- i_data_data  input  32  payload word.
- i_data_last  input  1  final payload word of the transfer.
- o_valid  output  1  outgoing FIS word valid.
- i_ready  input  1  link layer ready.
- o_data  output  32  outgoing word.
- o_last  output  1  last word of outgoing FIS.
- o_src  output  $clog2(NCHAN+1)  source of the current word: 0..NCHAN-1 = reg channel, NCHAN = DATA.

Behaviour:
- Reset: reset i_phy_reset_n, asynchronous, active-low; clock i_phy_clk. On reset: o_valid=0, o_data=0, o_last=0, o_src=0, state IDLE, round-robin pointer=0, payload counter=0, txgate synchroniser=0.
- i_txgate passes through a 2-FF synchroniser (gate_s). Gate changes take effect 2-3 cycles later.
- Output is a single registered stage. It updates only when adv = !o_valid || i_ready, and holds o_data/o_last/o_src stable while o_valid && !i_ready.
- States: IDLE, REG, DATA.
- IDLE, on adv:
  - If gate_s && i_data_valid: load header {8'h46, 24'h0}, o_last=0, o_src=NCHAN, counter=0, go to DATA. No payload word is consumed.
  - Else if any i_reg_valid: grant the first valid channel at or after the pointer, wrapping modulo NCHAN. Accept its word the same cycle and load it. If i_reg_last is high, remain IDLE; otherwise latch the channel and go to REG. Pointer becomes grant+1 mod NCHAN.
  - Else o_valid=0.
- REG: o_reg_ready[ch] = adv; all other readies are 0. Each accepted word is loaded. A word with last set returns the state to IDLE. If !i_reg_valid[ch] on adv, o_valid=0 (bubble) and the state holds. gate_s is ignored mid-packet.
- DATA:
  - o_data_ready = adv. Each accepted word is loaded and the counter increments.
  - o_last = i_data_last || (counter == MAXDATA-1).
  - When an accepted word has o_last set, return to IDLE. A split re-arbitrates: DATA still wins while gate_s && i_data_valid, and a fresh header precedes the remainder.
  - Underflow (!i_data_valid on adv) gives a bubble and the state holds.
  - gate_s falling mid-FIS does not abort the FIS.
- o_reg_ready is all-zero outside IDLE/REG grants. o_data_ready=0 outside DATA.
- At most one input word is accepted per cycle. Throughput is 1 word/cycle when i_ready is held high.
- Latency: input accept to o_valid is 1 cycle. Header appears 1 cycle after the grant.
- Only the asynchronous reset clears mid-FIS state. Reset mid-packet drops the packet; no resume.
- OPT_LOWPOWER=1: o_data, o_last and o_src are 0 on any cycle where o_valid loads 0.

Test Plan:
- NCHAN=2; ch0 sends 5-word FIS, ch1 a 3-word FIS, both valid at t0, i_ready=1 -> ch0 words 0..4 on cycles 1..5 with o_last on 5; ch1 words on 6..8; pointer=0 afterwards.
- Both channels continuously presenting 1-word FIS -> o_src alternates 0,1,0,1; no channel starved.
- i_txgate=1 (held ≥3 cycles), 4-word payload -> header 32'h4600_0000 then 4 payload words; o_last on the 4th; o_src=NCHAN on all 5.
- MAXDATA=4, 10-word payload with gate open -> FIS lengths 5,5,3 words including headers; o_last on payload words 4, 8 and 10.
- i_ready toggled 1,0,0,1 mid-FIS -> o_data/o_last/o_src stable while stalled; no word lost or duplicated; ready signals low on stall cycles.
- Reg channel mid-FIS when gate opens with data pending -> reg FIS completes first, then header; reset asserted mid-DATA -> o_valid=0 immediately, state IDLE after release.

Source files
------------

// File: rtl/satatrn_txmux.sv
// SATA transport transmit arbiter: merges round-robin register-FIS channels and a
// gated DATA payload source (with generated headers and length splitting) onto one FIS stream.
module satatrn_txmux #(
    parameter int NCHAN           = 2,
    parameter int MAXDATA         = 2048,
    parameter bit OPT_LOWPOWER    = 1'b0,
    localparam int SRCW           = $clog2(NCHAN + 1)
) (
    input  logic                  i_phy_clk,
    input  logic                  i_phy_reset_n,
    input  logic [NCHAN-1:0]      i_reg_valid,
    output logic [NCHAN-1:0]      o_reg_ready,
    input  logic [32*NCHAN-1:0]   i_reg_data,
    input  logic [NCHAN-1:0]      i_reg_last,
    input  logic                  i_txgate,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic [31:0]           i_data_data,
    input  logic                  i_data_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_data,
    output logic                  o_last,
    output logic [SRCW-1:0]       o_src
);

    localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int CNTW = $clog2(MAXDATA);
    localparam logic [31:0] DATA_HDR = {8'h46, 24'h0};

    typedef enum logic [1:0] {IDLE, REG, DATA} state_t;

    state_t           state_reg;
    logic [CHW-1:0]   ptr_reg;
    logic [CHW-1:0]   ch_reg;
    logic [CNTW-1:0]  cnt_reg;
    logic             gate_meta_reg;
    logic             gate_s_reg;

    logic [31:0]      chan_data [NCHAN];
    logic             adv;
    logic             data_win;
    logic             any_valid;
    logic             found;
    logic [CHW-1:0]   grant;
    logic [CHW-1:0]   idx_c;
    logic [CHW-1:0]   ptr_next;
    logic             data_last_eff;

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_unpack
        assign chan_data[gi] = i_reg_data[32*gi +: 32];
    end

    assign adv           = !o_valid || i_ready;
    assign data_win      = gate_s_reg && i_data_valid;
    assign any_valid     = |i_reg_valid;
    assign data_last_eff = i_data_last || (cnt_reg == CNTW'(MAXDATA - 1));
    assign ptr_next      = (grant == CHW'(NCHAN - 1)) ? '0 : grant + 1'b1;

    // First valid channel at or after the pointer, wrapping modulo NCHAN.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx_c = '0;
        for (int i = 0; i < NCHAN; i++) begin
            idx_c = CHW'((int'(ptr_reg) + i) % NCHAN);
            if (!found && i_reg_valid[idx_c]) begin
                found = 1'b1;
                grant = idx_c;
            end
        end
    end

    always_comb begin
        o_reg_ready  = '0;
        o_data_ready = 1'b0;
        case (state_reg)
            IDLE: if (adv && !data_win && any_valid) o_reg_ready[grant] = 1'b1;
            REG:  o_reg_ready[ch_reg] = adv;
            DATA: o_data_ready = adv;
            default: ;
        endcase
    end

    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            ch_reg        <= '0;
            cnt_reg       <= '0;
            gate_meta_reg <= 1'b0;
            gate_s_reg    <= 1'b0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_last        <= 1'b0;
            o_src         <= '0;
        end else begin
            gate_meta_reg <= i_txgate;
            gate_s_reg    <= gate_meta_reg;
            if (adv) begin
                // Bubble by default; each branch below overrides when a word is loaded.
                o_valid <= 1'b0;
                if (OPT_LOWPOWER) begin
                    o_data <= '0;
                    o_last <= 1'b0;
                    o_src  <= '0;
                end
                case (state_reg)
                    IDLE: begin
                        if (data_win) begin
                            o_valid   <= 1'b1;
                            o_data    <= DATA_HDR;
                            o_last    <= 1'b0;
                            o_src     <= SRCW'(NCHAN);
                            cnt_reg   <= '0;
                            state_reg <= DATA;
                        end else if (any_valid) begin
                            o_valid <= 1'b1;
                            o_data  <= chan_data[grant];
                            o_last  <= i_reg_last[grant];
                            o_src   <= SRCW'(grant);
                            ptr_reg <= ptr_next;
                            if (!i_reg_last[grant]) begin
                                ch_reg    <= grant;
                                state_reg <= REG;
                            end
                        end
                    end
                    REG: begin
                        if (i_reg_valid[ch_reg]) begin
                            o_valid <= 1'b1;
                            o_data  <= chan_data[ch_reg];
                            o_last  <= i_reg_last[ch_reg];
                            o_src   <= SRCW'(ch_reg);
                            if (i_reg_last[ch_reg]) state_reg <= IDLE;
                        end
                    end
                    DATA: begin
                        if (i_data_valid) begin
                            o_valid <= 1'b1;
                            o_data  <= i_data_data;
                            o_last  <= data_last_eff;
                            o_src   <= SRCW'(NCHAN);
                            cnt_reg <= cnt_reg + 1'b1;
                            if (data_last_eff) state_reg <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
